// File: rtl/mc_seq_decoder.sv
// ---------------------------------------------------------------------------
// mc_seq_decoder
//
// Microcode sequencer plus registered decoder for the mc8051 core. It takes
// an entry address for each opcode, reads a synchronous microcode ROM and
// steps through chained multi-cycle microwords. A word whose multi bit
// (bit 53) is set continues the chain. Each word is presented downstream as
// a registered control word with a valid/ready handshake.
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   i_op_valid/o_op_ready entry handshake (ready only while idle)
//   i_uaddr               microcode entry address
//   o_rom_en/o_rom_addr   registered ROM read strobe and address
//   i_rom_data            ROM data, valid one cycle after o_rom_en is sampled
//   o_ctl_valid/i_ctl_ready  control word handshake
//   o_mc_q                registered microword
//   o_alu_mode, o_jp_judg_mode, o_pc_reload_mode_sel, o_is_multi_cycles
//                         field slices of o_mc_q
//   o_step                index of the current word within the opcode
//   o_last                current valid word is the final one
//   i_flush               abort the running sequence
//   o_seq_err             one-cycle pulse when a chain overruns MAX_STEPS
// ---------------------------------------------------------------------------
module mc_seq_decoder #(
  parameter int MCODE_WIDTH = 54,
  parameter int UADDR_WIDTH = 9,
  parameter int MAX_STEPS   = 8,
  localparam int STEP_W     = $clog2(MAX_STEPS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  logic [UADDR_WIDTH-1:0] i_uaddr,
  output logic                   o_rom_en,
  output logic [UADDR_WIDTH-1:0] o_rom_addr,
  input  logic [MCODE_WIDTH-1:0] i_rom_data,
  output logic                   o_ctl_valid,
  input  logic                   i_ctl_ready,
  output logic [MCODE_WIDTH-1:0] o_mc_q,
  output logic [4:0]             o_alu_mode,
  output logic [3:0]             o_jp_judg_mode,
  output logic [2:0]             o_pc_reload_mode_sel,
  output logic                   o_is_multi_cycles,
  output logic [STEP_W-1:0]      o_step,
  output logic                   o_last,
  input  logic                   i_flush,
  output logic                   o_seq_err
);

  localparam int MULTI_BIT = 53;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                 state_reg,     state_next;
  logic                   rom_en_reg,    rom_en_next;
  logic [UADDR_WIDTH-1:0] rom_addr_reg,  rom_addr_next;
  logic [STEP_W-1:0]      step_reg,      step_next;
  logic [MCODE_WIDTH-1:0] mc_q_reg,      mc_q_next;
  logic                   ctl_valid_reg, ctl_valid_next;
  logic                   seq_err_reg,   seq_err_next;

  logic word_multi;
  logic step_at_max;

  assign word_multi  = mc_q_reg[MULTI_BIT];
  assign step_at_max = (step_reg == STEP_MAX);

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rom_en_next    = rom_en_reg;
    rom_addr_next  = rom_addr_reg;
    step_next      = step_reg;
    mc_q_next      = mc_q_reg;
    ctl_valid_next = ctl_valid_reg;
    seq_err_next   = 1'b0;

    if (i_flush) begin
      // Abort wins over everything except reset. In IDLE there is nothing
      // to abort, and an entry request in the same cycle is ignored.
      if (state_reg != ST_IDLE) begin
        ctl_valid_next = 1'b0;
        rom_en_next    = 1'b0;
        step_next      = '0;
        state_next     = ST_IDLE;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_op_valid) begin
            rom_addr_next = i_uaddr;
            rom_en_next   = 1'b1;
            step_next     = '0;
            state_next    = ST_FETCH;
          end
        end

        ST_FETCH: begin
          // FETCH spans two cycles: in the first the ROM samples the strobe,
          // in the second its output is valid and gets captured. The strobe
          // itself tells the two phases apart.
          if (rom_en_reg) begin
            rom_en_next = 1'b0;
          end else begin
            mc_q_next      = i_rom_data;
            ctl_valid_next = 1'b1;
            state_next     = ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (ctl_valid_reg && i_ctl_ready) begin
            ctl_valid_next = 1'b0;
            if (word_multi && !step_at_max) begin
              // Address increment wraps naturally at the address width.
              rom_addr_next = rom_addr_reg + UADDR_WIDTH'(1);
              rom_en_next   = 1'b1;
              step_next     = step_reg + STEP_W'(1);
              state_next    = ST_FETCH;
            end else begin
              // A chain that still asks for more words at the last allowed
              // step is malformed microcode.
              seq_err_next = word_multi;
              state_next   = ST_IDLE;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      rom_en_reg    <= 1'b0;
      rom_addr_reg  <= '0;
      step_reg      <= '0;
      mc_q_reg      <= '0;
      ctl_valid_reg <= 1'b0;
      seq_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rom_en_reg    <= rom_en_next;
      rom_addr_reg  <= rom_addr_next;
      step_reg      <= step_next;
      mc_q_reg      <= mc_q_next;
      ctl_valid_reg <= ctl_valid_next;
      seq_err_reg   <= seq_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_op_ready           = (state_reg == ST_IDLE);
  assign o_rom_en             = rom_en_reg;
  assign o_rom_addr           = rom_addr_reg;
  assign o_ctl_valid          = ctl_valid_reg;
  assign o_mc_q               = mc_q_reg;
  assign o_step               = step_reg;
  assign o_seq_err            = seq_err_reg;

  assign o_alu_mode           = mc_q_reg[30:26];
  assign o_jp_judg_mode       = mc_q_reg[43:40];
  assign o_pc_reload_mode_sel = mc_q_reg[46:44];
  assign o_is_multi_cycles    = mc_q_reg[MULTI_BIT];

  // Qualified by valid so that a stale or reset word never reads as "last".
  assign o_last = ctl_valid_reg & (~word_multi | step_at_max);

endmodule

// File: tb/tb_mc_seq_decoder.sv
// ---------------------------------------------------------------------------
// tb_mc_seq_decoder
//
// Directed bench for mc_seq_decoder with a behavioural synchronous ROM.
// Inputs change 1 time unit after the rising edge, outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mc_seq_decoder;

  localparam int MW = 54;
  localparam int AW = 9;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_op_valid;
  logic          o_op_ready;
  logic [AW-1:0] i_uaddr;
  logic          o_rom_en;
  logic [AW-1:0] o_rom_addr;
  logic [MW-1:0] i_rom_data;
  logic          o_ctl_valid;
  logic          i_ctl_ready;
  logic [MW-1:0] o_mc_q;
  logic [4:0]    o_alu_mode;
  logic [3:0]    o_jp_judg_mode;
  logic [2:0]    o_pc_reload_mode_sel;
  logic          o_is_multi_cycles;
  logic [SW-1:0] o_step;
  logic          o_last;
  logic          i_flush;
  logic          o_seq_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [MW-1:0] rom_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mc_seq_decoder #(
    .MCODE_WIDTH(MW),
    .UADDR_WIDTH(AW),
    .MAX_STEPS  (8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .i_op_valid          (i_op_valid),
    .o_op_ready          (o_op_ready),
    .i_uaddr             (i_uaddr),
    .o_rom_en            (o_rom_en),
    .o_rom_addr          (o_rom_addr),
    .i_rom_data          (i_rom_data),
    .o_ctl_valid         (o_ctl_valid),
    .i_ctl_ready         (i_ctl_ready),
    .o_mc_q              (o_mc_q),
    .o_alu_mode          (o_alu_mode),
    .o_jp_judg_mode      (o_jp_judg_mode),
    .o_pc_reload_mode_sel(o_pc_reload_mode_sel),
    .o_is_multi_cycles   (o_is_multi_cycles),
    .o_step              (o_step),
    .o_last              (o_last),
    .i_flush             (i_flush),
    .o_seq_err           (o_seq_err)
  );

  // Synchronous ROM: data appears one cycle after the strobe is sampled.
  always @(posedge clk) begin
    if (o_rom_en) i_rom_data <= rom_mem[o_rom_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [MW-1:0] mk(input logic [AW-1:0] a, input logic m);
    return {m, 44'hA5C396E1F0D, a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, ".op_ready"}, o_op_ready, 1);
    check_eq({tag, ".ctl_valid"}, o_ctl_valid, 0);
    check_eq({tag, ".rom_en"}, o_rom_en, 0);
    check_eq({tag, ".rom_addr"}, o_rom_addr, 0);
    check_eq({tag, ".mc_q"}, o_mc_q, 0);
    check_eq({tag, ".step"}, o_step, 0);
    check_eq({tag, ".last"}, o_last, 0);
    check_eq({tag, ".seq_err"}, o_seq_err, 0);
    check_eq({tag, ".alu"}, o_alu_mode, 0);
    check_eq({tag, ".multi"}, o_is_multi_cycles, 0);
  endtask

  // Present an entry for one edge and check the ROM strobe that follows.
  task automatic start_op(input string tag, input logic [AW-1:0] addr);
    check_eq({tag, ".ready_before"}, o_op_ready, 1);
    i_op_valid = 1'b1;
    i_uaddr    = addr;
    tick();
    i_op_valid = 1'b0;
    check_eq({tag, ".rom_en"}, o_rom_en, 1);
    check_eq({tag, ".rom_addr"}, o_rom_addr, addr);
    check_eq({tag, ".ready_busy"}, o_op_ready, 0);
    $display("entry %s addr=0x%03h", tag, addr);
  endtask

  // Two edges after a ROM strobe the word must be valid.
  task automatic expect_beat(input string tag, input logic [AW-1:0] addr,
                             input int step, input bit last);
    logic [MW-1:0] w;
    w = rom_mem[addr];
    tick();
    check_eq({tag, ".gap_valid"}, o_ctl_valid, 0);
    check_eq({tag, ".gap_rom_en"}, o_rom_en, 0);
    tick();
    check_eq({tag, ".valid"}, o_ctl_valid, 1);
    check_eq({tag, ".mc_q"}, o_mc_q, w);
    check_eq({tag, ".step"}, o_step, step);
    check_eq({tag, ".last"}, o_last, last);
    check_eq({tag, ".multi"}, o_is_multi_cycles, w[53]);
    check_eq({tag, ".alu"}, o_alu_mode, w[30:26]);
    check_eq({tag, ".jp"}, o_jp_judg_mode, w[43:40]);
    check_eq({tag, ".pc"}, o_pc_reload_mode_sel, w[46:44]);
    $display("beat  %s addr=0x%03h step=%0d last=%0b mc=0x%014h", tag, addr, o_step, o_last, o_mc_q);
  endtask

  task automatic consume();
    i_ctl_ready = 1'b1;
    tick();
    i_ctl_ready = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] held;
    logic [AW-1:0] a;

    reset_n     = 1'b0;
    i_op_valid  = 1'b0;
    i_uaddr     = '0;
    i_ctl_ready = 1'b0;
    i_flush     = 1'b0;
    i_rom_data  = '0;

    for (int k = 0; k < (1 << AW); k++) rom_mem[k] = mk(AW'(k), 1'b0);
    rom_mem[9'h010] = 54'h5900_5800_1234;  // alu=0x16 jp=0x9 pc=0x5 multi=0
    rom_mem[9'h020] = mk(9'h020, 1'b1);
    rom_mem[9'h021] = mk(9'h021, 1'b1);
    rom_mem[9'h022] = mk(9'h022, 1'b0);
    rom_mem[9'h030] = mk(9'h030, 1'b1);
    rom_mem[9'h031] = mk(9'h031, 1'b0);
    for (int k = 0; k < 9; k++) rom_mem[AW'(9'h1FC + k)] = mk(AW'(9'h1FC + k), 1'b1);

    // ---- reset state
    tick();
    tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();
    check_eq("post_reset.ready", o_op_ready, 1);

    // ---- single word
    start_op("single", 9'h010);
    expect_beat("single", 9'h010, 0, 1'b1);
    check_eq("single.alu_hand", o_alu_mode, 5'h16);
    check_eq("single.jp_hand", o_jp_judg_mode, 4'h9);
    check_eq("single.pc_hand", o_pc_reload_mode_sel, 3'h5);
    check_eq("single.ready_in_hold", o_op_ready, 0);
    consume();
    check_eq("single.done_valid", o_ctl_valid, 0);
    check_eq("single.done_ready", o_op_ready, 1);
    check_eq("single.no_err", o_seq_err, 0);

    // ---- chain of 3 with backpressure on the first beat
    start_op("chain", 9'h020);
    expect_beat("chain0", 9'h020, 0, 1'b0);
    held = o_mc_q;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("bp.valid", o_ctl_valid, 1);
      check_eq("bp.mc_q", o_mc_q, held);
      check_eq("bp.step", o_step, 0);
      check_eq("bp.rom_en", o_rom_en, 0);
    end
    $display("stall chain0 held 4 cycles");
    consume();
    check_eq("chain0.next_rom_en", o_rom_en, 1);
    check_eq("chain0.next_addr", o_rom_addr, 9'h021);
    check_eq("chain0.next_valid", o_ctl_valid, 0);
    expect_beat("chain1", 9'h021, 1, 1'b0);
    consume();
    check_eq("chain1.next_addr", o_rom_addr, 9'h022);
    expect_beat("chain2", 9'h022, 2, 1'b1);
    consume();
    check_eq("chain.done_ready", o_op_ready, 1);
    check_eq("chain.no_err", o_seq_err, 0);

    // ---- overrun with address wrap
    start_op("ovr", 9'h1FC);
    for (int k = 0; k < 8; k++) begin
      a = AW'(9'h1FC + k);
      expect_beat($sformatf("ovr%0d", k), a, k, k == 7);
      check_eq("ovr.err_early", o_seq_err, 0);
      consume();
      if (k < 7) begin
        a = AW'(9'h1FC + k + 1);
        check_eq($sformatf("ovr%0d.next_addr", k), o_rom_addr, a);
        check_eq("ovr.err_mid", o_seq_err, 0);
      end
    end
    check_eq("ovr.seq_err", o_seq_err, 1);
    check_eq("ovr.ready", o_op_ready, 1);
    check_eq("ovr.valid", o_ctl_valid, 0);
    check_eq("ovr.rom_en", o_rom_en, 0);
    tick();
    check_eq("ovr.err_pulse", o_seq_err, 0);
    $display("overrun seq_err pulse seen");

    // ---- flush during FETCH of beat 2
    start_op("fl", 9'h030);
    expect_beat("fl0", 9'h030, 0, 1'b0);
    consume();
    check_eq("fl.fetch_rom_en", o_rom_en, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check_eq("fl.ready", o_op_ready, 1);
    check_eq("fl.valid", o_ctl_valid, 0);
    check_eq("fl.rom_en", o_rom_en, 0);
    check_eq("fl.step", o_step, 0);
    check_eq("fl.seq_err", o_seq_err, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("fl.quiet_valid", o_ctl_valid, 0);
      check_eq("fl.quiet_ready", o_op_ready, 1);
    end
    $display("flush during fetch dropped beat 2");

    // flush together with an entry request in IDLE: entry ignored
    i_flush    = 1'b1;
    i_op_valid = 1'b1;
    i_uaddr    = 9'h020;
    tick();
    i_flush    = 1'b0;
    i_op_valid = 1'b0;
    check_eq("fl_idle.rom_en", o_rom_en, 0);
    check_eq("fl_idle.ready", o_op_ready, 1);
    $display("flush in idle ignored entry");

    start_op("after_fl", 9'h010);
    expect_beat("after_fl", 9'h010, 0, 1'b1);
    consume();

    // ---- reset while holding a word
    start_op("rst", 9'h020);
    expect_beat("rst0", 9'h020, 0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle_zero("mid_reset");
    $display("reset mid-hold cleared outputs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
